// File: rtl/cv32e40x_pkg.sv
// rtl/cv32e40x_pkg.sv - shared types and constants for the branch predictor
package cv32e40x_pkg;

    typedef enum logic {BP_IDLE, BP_REDIRECT} bp_state_e;

    // First-touch counter values: weakly taken / weakly not-taken
    localparam logic [1:0] BP_CNT_WT  = 2'b10;
    localparam logic [1:0] BP_CNT_WNT = 2'b01;

endpackage

// File: rtl/cv32e40x_bht.sv
// rtl/cv32e40x_bht.sv - 2-bit saturating counter table with valid bits
module cv32e40x_bht
    import cv32e40x_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 16,
    localparam int unsigned IDX_W      = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [1:0]       rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [BHT_ENTRIES-1:0] valid_q;
    logic [1:0]             cnt_q [BHT_ENTRIES];
    logic [1:0]             cnt_cur;
    logic [1:0]             cnt_nxt;

    // Reads see the pre-update contents; there is no write-to-read bypass
    assign rd_valid = valid_q[rd_idx];
    assign rd_cnt   = cnt_q[rd_idx];
    assign cnt_cur  = cnt_q[wr_idx];

    always_comb begin
        cnt_nxt = cnt_cur;
        if (!valid_q[wr_idx]) begin
            cnt_nxt = wr_taken ? BP_CNT_WT : BP_CNT_WNT;
        end else if (wr_taken) begin
            cnt_nxt = (cnt_cur == 2'b11) ? cnt_cur : cnt_cur + 2'b01;
        end else begin
            cnt_nxt = (cnt_cur == 2'b00) ? cnt_cur : cnt_cur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Counter contents are meaningless until their valid bit is set
    always_ff @(posedge clk) begin
        if (wr_en) begin
            cnt_q[wr_idx] <= cnt_nxt;
        end
    end

endmodule

// File: rtl/cv32e40x_bch_predictor.sv
// rtl/cv32e40x_bch_predictor.sv - branch direction predictor and mispredict redirect sequencer
module cv32e40x_bch_predictor
    import cv32e40x_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_i,
    input  logic        id_ready_i,
    input  logic        bch_in_id_i,
    input  logic [31:0] pc_id_i,
    input  logic [31:0] bch_target_i,
    output logic        bch_prediction_id_o,
    input  logic        ex_bch_resolved_i,
    input  logic        ex_bch_taken_i,
    input  logic        kill_i,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    input  logic        redirect_ready_i,
    output logic [31:0] mispredict_cnt_o
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    bp_state_e        state_q;
    logic [IDX_W-1:0] id_idx;
    logic             rd_valid;
    logic [1:0]       rd_cnt;
    logic             ex_pending_q;
    logic             ex_pred_q;
    logic [IDX_W-1:0] ex_idx_q;
    logic [31:0]      ex_target_q;
    logic [31:0]      ex_seq_q;
    logic             capture;
    logic             resolve;
    logic             mispredict;

    assign id_idx = pc_id_i[IDX_W+1:2];

    cv32e40x_bht #(
        .BHT_ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (id_idx),
        .rd_valid (rd_valid),
        .rd_cnt   (rd_cnt),
        .wr_en    (resolve),
        .wr_idx   (ex_idx_q),
        .wr_taken (ex_bch_taken_i)
    );

    // Untrained entries fall back to backward-taken / forward-not-taken
    assign bch_prediction_id_o = bch_in_id_i &&
                                 (rd_valid ? rd_cnt[1] : (bch_target_i < pc_id_i));

    assign capture    = id_valid_i && id_ready_i && bch_in_id_i && !kill_i &&
                        (state_q == BP_IDLE);
    assign resolve    = ex_bch_resolved_i && ex_pending_q;
    assign mispredict = resolve && (ex_bch_taken_i != ex_pred_q) &&
                        (state_q == BP_IDLE) && !kill_i;

    always_ff @(posedge clk) begin
        if (capture) begin
            ex_pred_q   <= bch_prediction_id_o;
            ex_idx_q    <= id_idx;
            ex_target_q <= bch_target_i;
            ex_seq_q    <= pc_id_i + 32'd4;
        end
    end

    // A capture in the resolving cycle keeps the slot occupied by the new branch
    always_ff @(posedge clk) begin
        if (rst || kill_i) begin
            ex_pending_q <= 1'b0;
        end else if (capture) begin
            ex_pending_q <= 1'b1;
        end else if (resolve) begin
            ex_pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= BP_IDLE;
            redirect_pc_o    <= '0;
            mispredict_cnt_o <= '0;
        end else if (kill_i) begin
            state_q <= BP_IDLE;
        end else begin
            case (state_q)
                BP_IDLE: begin
                    if (mispredict) begin
                        state_q       <= BP_REDIRECT;
                        redirect_pc_o <= ex_bch_taken_i ? ex_target_q : ex_seq_q;
                        if (mispredict_cnt_o != 32'hFFFF_FFFF) begin
                            mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
                        end
                    end
                end
                BP_REDIRECT: begin
                    if (redirect_ready_i) begin
                        state_q <= BP_IDLE;
                    end
                end
                default: state_q <= BP_IDLE;
            endcase
        end
    end

    assign redirect_valid_o = (state_q == BP_REDIRECT);

endmodule

// File: tb/tb_cv32e40x_bch_predictor.sv
// tb/tb_cv32e40x_bch_predictor.sv - scoreboard bench for cv32e40x_bch_predictor
module tb_cv32e40x_bch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid_i, id_ready_i, bch_in_id_i;
    logic [31:0] pc_id_i, bch_target_i;
    logic        bch_prediction_id_o;
    logic        ex_bch_resolved_i, ex_bch_taken_i, kill_i;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        redirect_ready_i;
    logic [31:0] mispredict_cnt_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
    } redir_t;

    redir_t exp_q[$];
    int     checks   = 0;
    int     failures = 0;
    int     mp_model = 0;
    logic   prev_v   = 1'b0;

    cv32e40x_bch_predictor #(.BHT_ENTRIES(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .id_valid_i          (id_valid_i),
        .id_ready_i          (id_ready_i),
        .bch_in_id_i         (bch_in_id_i),
        .pc_id_i             (pc_id_i),
        .bch_target_i        (bch_target_i),
        .bch_prediction_id_o (bch_prediction_id_o),
        .ex_bch_resolved_i   (ex_bch_resolved_i),
        .ex_bch_taken_i      (ex_bch_taken_i),
        .kill_i              (kill_i),
        .redirect_valid_o    (redirect_valid_o),
        .redirect_pc_o       (redirect_pc_o),
        .redirect_ready_i    (redirect_ready_i),
        .mispredict_cnt_o    (mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every new redirect must match the oldest expected one
    always @(negedge clk) begin
        if (!rst && redirect_valid_o && !prev_v) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_redirect actual=%h required=none", redirect_pc_o);
            end else begin
                redir_t e;
                e = exp_q.pop_front();
                chk("redirect_pc", redirect_pc_o, e.pc);
                chk("redirect_cnt", mispredict_cnt_o, e.cnt);
            end
        end
        prev_v = redirect_valid_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_redirect(input logic [31:0] pc);
        redir_t e;
        mp_model++;
        e.pc  = pc;
        e.cnt = mp_model;
        exp_q.push_back(e);
    endtask

    task automatic set_id(input logic [31:0] pc, input logic [31:0] tgt, input logic v);
        bch_in_id_i  = 1'b1;
        id_valid_i   = v;
        id_ready_i   = v;
        pc_id_i      = pc;
        bch_target_i = tgt;
        #0;
    endtask

    task automatic clr();
        id_valid_i = 0; id_ready_i = 0; bch_in_id_i = 0;
        ex_bch_resolved_i = 0; ex_bch_taken_i = 0; kill_i = 0;
    endtask

    // Capture one branch, then resolve it the next cycle
    task automatic branch(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic exp_pred, input logic taken);
        set_id(pc, tgt, 1'b1);
        #1;
        chk("branch_pred", bch_prediction_id_o, exp_pred);
        step();
        clr();
        ex_bch_resolved_i = 1'b1;
        ex_bch_taken_i    = taken;
        if (taken != exp_pred) expect_redirect(taken ? tgt : pc + 32'd4);
        step();
        clr();
    endtask

    task automatic release_redirect();
        int n = 0;
        while (!redirect_valid_o && n < 10) begin
            step();
            n++;
        end
        if (!redirect_valid_o) begin
            checks++;
            failures++;
            $display("FAIL redirect_timeout actual=0 required=1");
        end
        redirect_ready_i = 1'b1;
        step();
        redirect_ready_i = 1'b0;
        chk("redirect_drop", redirect_valid_o, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        clr();
        redirect_ready_i = 0;
        pc_id_i = 0;
        bch_target_i = 0;
        step();
        step();
        rst = 1'b0;
        chk("reset_valid", redirect_valid_o, 1'b0);
        chk("reset_pc", redirect_pc_o, 32'h0);
        chk("reset_cnt", mispredict_cnt_o, 32'h0);

        // Static fallback
        set_id(32'h100, 32'h0F0, 1'b0); #1;
        chk("static_backward", bch_prediction_id_o, 1'b1);
        set_id(32'h100, 32'h110, 1'b0); #1;
        chk("static_forward", bch_prediction_id_o, 1'b0);
        bch_in_id_i = 1'b0; #1;
        chk("not_branch", bch_prediction_id_o, 1'b0);

        // First mispredict, then hold redirect for 5 cycles
        branch(32'h100, 32'h0F0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", redirect_valid_o, 1'b1);
            chk("hold_pc", redirect_pc_o, 32'h104);
            step();
        end
        release_redirect();
        set_id(32'h100, 32'h0F0, 1'b0); #1;
        chk("trained_wnt", bch_prediction_id_o, 1'b0);
        clr();

        // Train taken to saturation, then one not-taken keeps it taken
        branch(32'h100, 32'h0F0, 1'b0, 1'b1);
        release_redirect();
        branch(32'h100, 32'h0F0, 1'b1, 1'b1);
        branch(32'h100, 32'h0F0, 1'b1, 1'b1);
        chk("no_redirect_correct", redirect_valid_o, 1'b0);
        chk("cnt_after_correct", mispredict_cnt_o, 32'd2);
        branch(32'h100, 32'h0F0, 1'b1, 1'b0);
        release_redirect();
        set_id(32'h100, 32'h0F0, 1'b0); #1;
        chk("saturated_pred", bch_prediction_id_o, 1'b1);
        clr();

        // Kill during redirect while a second branch is pending
        set_id(32'h208, 32'h100, 1'b1); #1;
        chk("pred_a", bch_prediction_id_o, 1'b1);
        step();
        clr();
        set_id(32'h304, 32'h400, 1'b1);
        ex_bch_resolved_i = 1'b1;
        ex_bch_taken_i    = 1'b0;
        #1;
        chk("pred_b", bch_prediction_id_o, 1'b0);
        expect_redirect(32'h20C);
        step();
        clr();
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        chk("kill_idle", redirect_valid_o, 1'b0);
        ex_bch_resolved_i = 1'b1;
        ex_bch_taken_i    = 1'b1;
        step();
        clr();
        step();
        chk("kill_no_redirect", redirect_valid_o, 1'b0);
        chk("kill_cnt", mispredict_cnt_o, 32'd4);
        set_id(32'h304, 32'h400, 1'b0); #1;
        chk("kill_no_update", bch_prediction_id_o, 1'b0);
        clr();

        // PC wrap, with capture in the resolving cycle
        set_id(32'hFFFF_FFFC, 32'h1000, 1'b1); #1;
        chk("pred_wrap", bch_prediction_id_o, 1'b1);
        step();
        clr();
        set_id(32'h110, 32'h200, 1'b1);
        ex_bch_resolved_i = 1'b1;
        ex_bch_taken_i    = 1'b0;
        #1;
        chk("pred_c", bch_prediction_id_o, 1'b0);
        expect_redirect(32'h0);
        step();
        clr();
        release_redirect();
        ex_bch_resolved_i = 1'b1;
        ex_bch_taken_i    = 1'b1;
        expect_redirect(32'h200);
        step();
        clr();
        release_redirect();
        chk("final_cnt", mispredict_cnt_o, 32'd6);

        step();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
